paddle_ctl: RTL and testbench
=============================

// Module: paddle_ctl
// PURPOSE
//  Arkanoid paddle controller with configurable playfield and fall dynamics.
//  Tracks mouse X, clamped so the whole paddle stays inside [X_MIN, X_MAX].
//  Left click makes the paddle drop with accelerating speed to Y_LAND.
//  The paddle holds there until the mouse moves, then climbs back to Y_REST.
//  Sits between the mouse controller and the paddle draw/collision logic.
// PARAMETERS
//  X_MIN      0       leftmost paddle x (px)
//  X_MAX      800     right playfield edge; paddle x <= X_MAX-PAD_W
//  PAD_W      128     paddle width (px); X_MAX >= X_MIN+PAD_W required
//  Y_REST     500     normal paddle y
//  Y_LAND     535     y where a fall ends; Y_LAND > Y_REST required
//  STEP_W     17      width of fall-delay counters
//  STEP_INIT  100000  pclk cycles before first fall pixel
//  STEP_DEC   200     delay decrease per fallen pixel
//  STEP_MIN   1000    delay floor
//  MAX_STEP   8       px per frame_tick, SMOOTH_EN only
// PORTS
//  pclk        in   1   pixel clock
//  reset       in   1   sync active-high reset
//  frame_tick  in   1   one-pclk pulse per frame
//  mouse_xpos  in   12  raw mouse x
//  mouse_left  in   1   left button level
//  xpos        out  12  paddle left edge x (registered)
//  ypos        out  12  paddle top y (registered)
//  falling     out  1   1 while state FALL
//  landed      out  1   1 while state HOLD
// BEHAVIOUR
//  - Reset is synchronous and active-high; clock is pclk. All outputs are registered.
//  - Reset, including mid-fall: state TRACK, xpos=X_MIN, ypos=Y_REST, falling=0,
//    landed=0, counters=0, left_d=0.
//  - Clamp: tgt = mouse_xpos<X_MIN ? X_MIN : mouse_xpos>X_MAX-PAD_W ? X_MAX-PAD_W
//    : mouse_xpos. Compare in 13 bits unsigned; no wrap for any mouse_xpos.
//  - X update, TRACK/RISE only: xpos<=tgt every cycle (1-cycle latency).
//    xpos is frozen in FALL and HOLD.
//  - left_d is mouse_left registered. click = mouse_left & ~left_d (rising edge).
//  - TRACK: ypos=Y_REST. On click: go to FALL, delay<=STEP_INIT, step_cnt<=STEP_INIT.
//    Level-held button causes no retrigger. Clicks in other states are ignored.
//  - FALL: each cycle, if step_cnt!=0 then step_cnt--.
//    Else: ypos++, delay<=max(delay-STEP_DEC, STEP_MIN) with no underflow,
//    and step_cnt<=that new delay.
//    When ypos reaches Y_LAND, in the same cycle: go to HOLD, xhold<=mouse_xpos.
//  - HOLD: ypos=Y_LAND. When mouse_xpos != xhold: go to RISE.
//  - RISE: on each frame_tick, ypos-- . At ypos==Y_REST: go to TRACK.
//    A click and a frame_tick in the same cycle: the tick is applied, the click is ignored.
//  - falling/landed are decoded from the state register, so they are valid in
//    the same cycle the state is.
// CONFIGURATION
//  SMOOTH_EN defined: in TRACK/RISE, xpos moves toward tgt only on frame_tick,
//    by min(|tgt-xpos|, MAX_STEP). It never overshoots and stays clamped.
//  SMOOTH_EN undefined: direct tracking as above; MAX_STEP unused.
// TESTING (bench params: STEP_INIT=10, STEP_DEC=2, STEP_MIN=4, Y_LAND=503)
//  1 Reset, mouse_xpos=300 -> next cycle xpos=300, ypos=500, falling=0.
//  2 mouse_xpos=4000 -> xpos=672. mouse_xpos=0 with X_MIN=16 -> xpos=16.
//  3 Click at cycle c -> falling=1 at c+1. ypos=501 at c+12, 502 at c+21,
//    503 at c+28, then landed=1. Holding the button causes no refall.
//  4 In HOLD, change mouse_xpos -> RISE; ypos 502, 501, 500 on 3 frame_ticks;
//    then TRACK and xpos follows the mouse.
//  5 Reset asserted while ypos=502 in FALL -> next cycle ypos=500, falling=0, TRACK.
//  6 SMOOTH_EN, xpos=100, tgt=130 -> after ticks 108, 116, 124, 130, 130.

Source files
------------

// File: rtl/paddle_ctl.sv
// Paddle controller for an Arkanoid-style playfield.
// Tracks the mouse horizontally, clamped so the paddle stays inside [X_MIN, X_MAX].
// A left click drops the paddle with accelerating speed to Y_LAND.
// It holds there until the mouse moves, then climbs back to Y_REST, one pixel per frame.
// Optional build macro SMOOTH_EN: x moves toward the target on frame_tick only,
// by at most MAX_STEP pixels per tick. Without it, x follows the target every cycle.
module paddle_ctl #(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 800,
  parameter int PAD_W     = 128,
  parameter int Y_REST    = 500,
  parameter int Y_LAND    = 535,
  parameter int STEP_W    = 17,
  parameter int STEP_INIT = 100000,
  parameter int STEP_DEC  = 200,
  parameter int STEP_MIN  = 1000,
  parameter int MAX_STEP  = 8
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [11:0] mouse_xpos,
  input  logic        mouse_left,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        falling,
  output logic        landed
);

  typedef enum logic [1:0] {
    TRACK,
    FALL,
    HOLD,
    RISE
  } state_t;

  localparam logic [12:0]       X_LO  = 13'(X_MIN);
  localparam logic [12:0]       X_HI  = 13'(X_MAX - PAD_W);
  localparam logic [11:0]       Y_R   = 12'(Y_REST);
  localparam logic [11:0]       Y_L   = 12'(Y_LAND);
  localparam logic [STEP_W-1:0] D_INI = STEP_W'(STEP_INIT);
  localparam logic [STEP_W-1:0] D_DEC = STEP_W'(STEP_DEC);
  localparam logic [STEP_W-1:0] D_MIN = STEP_W'(STEP_MIN);
  // Above this delay, subtracting STEP_DEC still leaves more than the floor.
  localparam logic [STEP_W:0]   D_FLR = (STEP_W + 1)'(STEP_MIN + STEP_DEC);

  state_t            state, state_n;
  logic [11:0]       xpos_n, ypos_n;
  logic [11:0]       xhold, xhold_n;
  logic [STEP_W-1:0] delay, delay_n;
  logic [STEP_W-1:0] step_cnt, step_n;
  logic [STEP_W-1:0] delay_dec;
  logic              left_d;
  logic              click;
  logic [11:0]       tgt;
  logic [12:0]       mx13;

  assign click   = mouse_left & ~left_d;
  assign falling = (state == FALL);
  assign landed  = (state == HOLD);

  // Clamp the raw mouse x so the whole paddle stays inside the playfield.
  always_comb begin
    mx13 = {1'b0, mouse_xpos};
    if (mx13 < X_LO)
      tgt = X_LO[11:0];
    else if (mx13 > X_HI)
      tgt = X_HI[11:0];
    else
      tgt = mouse_xpos;
  end

  // Next fall delay: shrink by STEP_DEC but never below STEP_MIN, without underflow.
  always_comb begin
    if ({1'b0, delay} > D_FLR)
      delay_dec = delay - D_DEC;
    else
      delay_dec = D_MIN;
  end

`ifdef SMOOTH_EN
  localparam logic [11:0] M_STEP = 12'(MAX_STEP);
  logic [11:0] xpos_step;
  logic [11:0] xdiff;

  // Move one bounded step toward the target, never past it.
  always_comb begin
    if (tgt > xpos) begin
      xdiff     = tgt - xpos;
      xpos_step = xpos + ((xdiff > M_STEP) ? M_STEP : xdiff);
    end else begin
      xdiff     = xpos - tgt;
      xpos_step = xpos - ((xdiff > M_STEP) ? M_STEP : xdiff);
    end
  end
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_n = state;
    xpos_n  = xpos;
    ypos_n  = ypos;
    delay_n = delay;
    step_n  = step_cnt;
    xhold_n = xhold;

    if (state == TRACK || state == RISE) begin
`ifdef SMOOTH_EN
      if (frame_tick)
        xpos_n = xpos_step;
`else
      xpos_n = tgt;
`endif
    end

    unique case (state)
      TRACK: begin
        ypos_n = Y_R;
        if (click) begin
          state_n = FALL;
          delay_n = D_INI;
          step_n  = D_INI;
        end
      end
      FALL: begin
        if (step_cnt != '0) begin
          step_n = step_cnt - STEP_W'(1);
        end else begin
          ypos_n  = ypos + 12'd1;
          delay_n = delay_dec;
          step_n  = delay_dec;
          // Leave for HOLD on the same edge that lands the last pixel.
          if (ypos + 12'd1 == Y_L) begin
            state_n = HOLD;
            xhold_n = mouse_xpos;
          end
        end
      end
      HOLD: begin
        ypos_n = Y_L;
        if (mouse_xpos != xhold)
          state_n = RISE;
      end
      RISE: begin
        if (frame_tick) begin
          ypos_n = ypos - 12'd1;
          if (ypos - 12'd1 == Y_R)
            state_n = TRACK;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state    <= TRACK;
      xpos     <= X_LO[11:0];
      ypos     <= Y_R;
      xhold    <= '0;
      delay    <= '0;
      step_cnt <= '0;
      left_d   <= 1'b0;
    end else begin
      state    <= state_n;
      xpos     <= xpos_n;
      ypos     <= ypos_n;
      xhold    <= xhold_n;
      delay    <= delay_n;
      step_cnt <= step_n;
      left_d   <= mouse_left;
    end
  end

endmodule

// File: tb/tb_paddle_ctl.sv
// Bench for paddle_ctl: a reference model predicts outputs at every clock edge
// into a queue; a monitor pops and compares on the opposite edge.
// Directed scenarios are followed by randomized mouse/click/tick/reset traffic.
module tb_paddle_ctl;
  localparam int X_MIN     = 16;
  localparam int X_MAX     = 800;
  localparam int PAD_W     = 128;
  localparam int Y_REST    = 500;
  localparam int Y_LAND    = 503;
  localparam int STEP_INIT = 10;
  localparam int STEP_DEC  = 2;
  localparam int STEP_MIN  = 4;
  localparam int MAX_STEP  = 8;

  localparam int M_TRACK = 0;
  localparam int M_FALL  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_RISE  = 3;

  logic        pclk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [11:0] mouse_xpos;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        falling;
  logic        landed;

  always #5 pclk = ~pclk;

  paddle_ctl #(
    .X_MIN    (X_MIN),
    .X_MAX    (X_MAX),
    .PAD_W    (PAD_W),
    .Y_REST   (Y_REST),
    .Y_LAND   (Y_LAND),
    .STEP_W   (17),
    .STEP_INIT(STEP_INIT),
    .STEP_DEC (STEP_DEC),
    .STEP_MIN (STEP_MIN),
    .MAX_STEP (MAX_STEP)
  ) dut (
    .pclk      (pclk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .mouse_xpos(mouse_xpos),
    .mouse_left(mouse_left),
    .xpos      (xpos),
    .ypos      (ypos),
    .falling   (falling),
    .landed    (landed)
  );

  typedef struct {
    int x;
    int y;
    bit f;
    bit l;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: mode, position, and the absolute edge numbers at
  // which the remaining fall pixels are due.
  int m_mode = M_TRACK;
  int mx     = X_MIN;
  int my     = Y_REST;
  int mxhold = 0;
  bit m_left = 1'b0;
  int fall_at[$];
  int cyc    = 0;

  function automatic int clampx(input int v);
    if (v < X_MIN) return X_MIN;
    if (v > X_MAX - PAD_W) return X_MAX - PAD_W;
    return v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance one edge from the inputs seen at this edge.
  always @(posedge pclk) begin
    exp_t e;
    int   tgt;
    int   d;
    int   t;
    cyc++;
    if (reset) begin
      m_mode = M_TRACK;
      mx     = X_MIN;
      my     = Y_REST;
      m_left = 1'b0;
      fall_at.delete();
    end else begin
      tgt = clampx(int'(mouse_xpos));
      if (m_mode == M_TRACK || m_mode == M_RISE) begin
`ifdef SMOOTH_EN
        if (frame_tick) begin
          if (tgt > mx) mx = mx + imin(tgt - mx, MAX_STEP);
          else          mx = mx - imin(mx - tgt, MAX_STEP);
        end
`else
        mx = tgt;
`endif
      end
      case (m_mode)
        M_TRACK: begin
          if (mouse_left && !m_left) begin
            m_mode = M_FALL;
            fall_at.delete();
            t = cyc;
            d = STEP_INIT;
            for (int k = 0; k < Y_LAND - Y_REST; k++) begin
              t = t + d + 1;
              fall_at.push_back(t);
              d = (d - STEP_DEC > STEP_MIN) ? d - STEP_DEC : STEP_MIN;
            end
          end
        end
        M_FALL: begin
          if (fall_at.size() > 0 && fall_at[0] == cyc) begin
            void'(fall_at.pop_front());
            my++;
            if (my == Y_LAND) begin
              m_mode = M_HOLD;
              mxhold = int'(mouse_xpos);
            end
          end
        end
        M_HOLD: begin
          if (int'(mouse_xpos) != mxhold) m_mode = M_RISE;
        end
        default: begin
          if (frame_tick) begin
            my--;
            if (my == Y_REST) m_mode = M_TRACK;
          end
        end
      endcase
      m_left = mouse_left;
    end
    e.x = mx;
    e.y = my;
    e.f = (m_mode == M_FALL);
    e.l = (m_mode == M_HOLD);
    sbq.push_back(e);
  end

  // Monitor: compare DUT outputs with the prediction for the last edge.
  always @(negedge pclk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (int'(xpos) != e.x || int'(ypos) != e.y || falling != e.f || landed != e.l) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got x=%0d y=%0d f=%0b l=%0b expected x=%0d y=%0d f=%0b l=%0b",
                 $time, xpos, ypos, falling, landed, e.x, e.y, e.f, e.l);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    mouse_left = 1'b0;
    mouse_xpos = 12'd300;
    repeat (3) @(negedge pclk);
    chk("reset_x", int'(xpos), X_MIN);
    chk("reset_y", int'(ypos), Y_REST);
    chk("reset_falling", int'(falling), 0);
    reset = 1'b0;
    @(negedge pclk);
`ifndef SMOOTH_EN
    chk("track_x300", int'(xpos), 300);
`endif
    chk("rest_y", int'(ypos), Y_REST);
    chk("rest_falling", int'(falling), 0);

`ifndef SMOOTH_EN
    mouse_xpos = 12'd4000;
    @(negedge pclk);
    chk("clamp_high", int'(xpos), 672);
    mouse_xpos = 12'd0;
    @(negedge pclk);
    chk("clamp_low", int'(xpos), 16);
`endif
    mouse_xpos = 12'd300;
    @(negedge pclk);

    // Fall timing from a click, button held throughout.
    mouse_left = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge pclk);
      if (k == 1)  chk("fall_start", int'(falling), 1);
      if (k == 11) chk("fall_y_k11", int'(ypos), 500);
      if (k == 12) chk("fall_y_k12", int'(ypos), 501);
      if (k == 20) chk("fall_y_k20", int'(ypos), 501);
      if (k == 21) chk("fall_y_k21", int'(ypos), 502);
      if (k == 27) chk("fall_y_k27", int'(ypos), 502);
      if (k == 28) begin
        chk("land_y", int'(ypos), 503);
        chk("land_flag", int'(landed), 1);
      end
    end
    repeat (20) @(negedge pclk);
    chk("hold_landed", int'(landed), 1);
    chk("hold_y", int'(ypos), 503);
    mouse_left = 1'b0;
    @(negedge pclk);
    mouse_left = 1'b1;
    repeat (3) @(negedge pclk);
    chk("hold_click_ignored", int'(landed), 1);
    mouse_left = 1'b0;

    // Mouse motion releases the hold; climb one pixel per frame.
    mouse_xpos = 12'd350;
    @(negedge pclk);
    chk("rise_enter", int'(landed), 0);
    chk("rise_y0", int'(ypos), 503);
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      @(negedge pclk);
      frame_tick = 1'b0;
      chk("rise_y", int'(ypos), 502 - i);
      @(negedge pclk);
    end
`ifndef SMOOTH_EN
    mouse_xpos = 12'd420;
    @(negedge pclk);
    chk("track_after_rise", int'(xpos), 420);
`endif

    // Reset in the middle of a fall.
    mouse_left = 1'b1;
    repeat (21) @(negedge pclk);
    chk("midfall_y", int'(ypos), 502);
    reset = 1'b1;
    @(negedge pclk);
    chk("midfall_reset_y", int'(ypos), 500);
    chk("midfall_reset_falling", int'(falling), 0);
    chk("midfall_reset_x", int'(xpos), X_MIN);
    reset      = 1'b0;
    mouse_left = 1'b0;
    @(negedge pclk);

`ifdef SMOOTH_EN
    mouse_xpos = 12'd100;
    for (int i = 0; i < 200 && xpos != 12'd100; i++) begin
      frame_tick = 1'b1;
      @(negedge pclk);
      frame_tick = 1'b0;
      @(negedge pclk);
    end
    chk("smooth_setup", int'(xpos), 100);
    mouse_xpos = 12'd130;
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      @(negedge pclk);
      frame_tick = 1'b0;
      chk("smooth_step", int'(xpos), imin(100 + 8 * (i + 1), 130));
      @(negedge pclk);
    end
`endif

    // Randomized traffic.
    for (int n = 0; n < 20000; n++) begin
      @(negedge pclk);
      reset      = ($urandom_range(0, 499) == 0);
      frame_tick = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) mouse_left = ~mouse_left;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0:       mouse_xpos = 12'($urandom_range(0, 4095));
          1:       mouse_xpos = 12'($urandom_range(0, 32));
          2:       mouse_xpos = 12'($urandom_range(660, 690));
          default: mouse_xpos = 12'($urandom_range(0, 799));
        endcase
      end
    end
    reset      = 1'b0;
    frame_tick = 1'b0;
    repeat (2) @(negedge pclk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
